pilha_lifo: RTL and testbench
=============================

Name: pilha_lifo

Overview:
16-bit LIFO operand stack consumed directly downstream of the control unit. The control unit drives a one-cycle operation strobe with a write/read select and a source select. The stack then pushes either the memory/immediate operand or the ALU result, or pops the top value toward the temp registers and the data RAM. It reports empty/full status and sticky overflow/underflow errors.

Parameters:
WIDTH, 16, data word width
DEPTH, 16, number of stack entries (power of two, at least 2)
PTR_W, 5, stack-pointer width; must satisfy 2^PTR_W > DEPTH, so count DEPTH is representable

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  operation strobe; one operation per cycle in which it is high (replaces the gated stack clock)
wren  input  1  1 = push, 0 = pop; sampled only when enable=1
controle  input  1  push source: 0 = data_in, 1 = ula_in
data_in  input  WIDTH  operand from data RAM or immediate field
ula_in  input  WIDTH  ALU result
data_out  output  WIDTH  value removed by the last successful pop
topo  output  WIDTH  current top-of-stack; 0 when empty
count  output  PTR_W  number of valid entries
vazio  output  1  count == 0
cheio  output  1  count == DEPTH
erro_overflow  output  1  sticky: push attempted while full
erro_underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (sync, high): sp/count=0, data_out=0, topo=0, erro_overflow=0, erro_underflow=0. vazio=1, cheio=0. Memory contents are not cleared and are don't-care. Reset overrides any simultaneous enable.
- Idle (enable=0): no state change. wren, controle and the data inputs are ignored.
- Push (enable=1, wren=1, not full):
  - val = controle ? ula_in : data_in.
  - mem[sp] <= val; sp <= sp+1; topo <= val.
  - The new topo and count are visible the cycle after the strobe (1-cycle latency).
- Push while full: no write; sp, topo and data_out are unchanged; erro_overflow <= 1.
- Pop (enable=1, wren=0, not empty):
  - data_out <= mem[sp-1]; sp <= sp-1.
  - topo <= mem[sp-2] if sp >= 2, else 0.
  - data_out is valid the cycle after the strobe.
- Pop while empty: data_out, topo and sp are unchanged; erro_underflow <= 1.
- Error flags are sticky and cleared only by reset. Setting one does not block later legal operations.
- vazio and cheio are combinational decodes of the registered count; no extra latency.
- Back-to-back strobes on consecutive cycles are legal. Push then pop on the next cycle returns the pushed value.
- controle is ignored on pops.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package pilha_pkg:
  - constants WIDTH=16, DEPTH=16, PTR_W=5;
  - encodings OP_POP=0, OP_PUSH=1;
  - SRC_DADO=0, SRC_ULA=1.
  - The control unit uses the same constants.
- One sub-module: pilha_mem.
  - DEPTH x WIDTH register file: synchronous write port, two combinational read addresses (sp-1, sp-2).
  - No reset on the array.
- Pointer, flag and output registers live in pilha_lifo.

Test Plan:
- Reset then idle 3 cycles -> count=0, vazio=1, cheio=0, topo=0, data_out=0, both error flags 0.
- Push data_in=0x0005, 0x00A0, 0x1234 (controle=0), then pop x3 -> topo 0x1234 before the pops; data_out 0x1234, 0x00A0, 0x0005 on successive cycles; finally vazio=1, topo=0.
- Push with controle=1, ula_in=0xBEEF, data_in=0x0001 -> topo=0xBEEF. Pop -> data_out=0xBEEF.
- Push 16 values 1..16, then one more push of 0x00FF -> cheio=1, erro_overflow=1, topo stays 16. Pop -> data_out=16.
- From empty, pop -> erro_underflow=1, data_out holds the previous value. Push 7 -> count=1, erro_underflow still 1.
- Push 2 values, assert reset in the same cycle as a push strobe -> next cycle count=0, topo=0, flags 0. enable=0 with wren toggling leaves all state unchanged.

Source files
------------

// File: rtl/pilha_pkg.sv
// Shared constants for the operand stack and the control unit that drives it.
package pilha_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PTR_W = 5;

  // wren encoding
  localparam logic OP_POP  = 1'b0;
  localparam logic OP_PUSH = 1'b1;

  // controle encoding (push source)
  localparam logic SRC_DADO = 1'b0;
  localparam logic SRC_ULA  = 1'b1;

endpackage

// File: rtl/pilha_mem.sv
// Stack storage: one synchronous write port, two combinational read ports.
module pilha_mem #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr_a,
  input  logic [AW-1:0]    i_raddr_b,
  output logic [WIDTH-1:0] o_rdata_a,
  output logic [WIDTH-1:0] o_rdata_b
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Array is never reset; contents past the stack pointer are don't-care.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/pilha_lifo.sv
// LIFO operand stack with empty/full status and sticky overflow/underflow errors.
module pilha_lifo #(
  parameter int unsigned WIDTH = pilha_pkg::WIDTH,
  parameter int unsigned DEPTH = pilha_pkg::DEPTH,
  parameter int unsigned PTR_W = pilha_pkg::PTR_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             wren,
  input  logic             controle,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] ula_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] topo,
  output logic [PTR_W-1:0] count,
  output logic             vazio,
  output logic             cheio,
  output logic             erro_overflow,
  output logic             erro_underflow
);

  import pilha_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  logic [PTR_W-1:0] r_sp;
  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_topo;
  logic             r_ovf;
  logic             r_unf;

  logic             w_vazio;
  logic             w_cheio;
  logic             w_push;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [WIDTH-1:0] w_push_val;
  logic [AW-1:0]    w_addr_m1;
  logic [AW-1:0]    w_addr_m2;
  logic [WIDTH-1:0] w_rd_m1;
  logic [WIDTH-1:0] w_rd_m2;

  assign w_vazio    = (r_sp == '0);
  assign w_cheio    = (r_sp == PTR_W'(DEPTH));
  assign w_push     = enable && (wren == OP_PUSH);
  assign w_pop      = enable && (wren == OP_POP);
  assign w_push_ok  = w_push && !w_cheio;
  assign w_pop_ok   = w_pop && !w_vazio;
  assign w_push_val = (controle == SRC_ULA) ? ula_in : data_in;

  // Wrap modulo DEPTH is harmless: these reads are only used when sp is large enough.
  assign w_addr_m1 = r_sp[AW-1:0] - AW'(1);
  assign w_addr_m2 = r_sp[AW-1:0] - AW'(2);

  pilha_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk     (clock),
    .i_we      (w_push_ok),
    .i_waddr   (r_sp[AW-1:0]),
    .i_wdata   (w_push_val),
    .i_raddr_a (w_addr_m1),
    .i_raddr_b (w_addr_m2),
    .o_rdata_a (w_rd_m1),
    .o_rdata_b (w_rd_m2)
  );

  // Stack pointer, output registers and sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sp       <= '0;
      r_data_out <= '0;
      r_topo     <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_sp   <= r_sp + PTR_W'(1);
        r_topo <= w_push_val;
      end else if (w_pop_ok) begin
        r_sp       <= r_sp - PTR_W'(1);
        r_data_out <= w_rd_m1;
        r_topo     <= (r_sp >= PTR_W'(2)) ? w_rd_m2 : '0;
      end
      if (w_push && w_cheio) begin
        r_ovf <= 1'b1;
      end
      if (w_pop && w_vazio) begin
        r_unf <= 1'b1;
      end
    end
  end

  assign data_out       = r_data_out;
  assign topo           = r_topo;
  assign count          = r_sp;
  assign vazio          = w_vazio;
  assign cheio          = w_cheio;
  assign erro_overflow  = r_ovf;
  assign erro_underflow = r_unf;

endmodule

// File: tb/tb_pilha_lifo.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_pilha_lifo;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PTR_W = 5;

  logic             clock;
  logic             reset;
  logic             enable;
  logic             wren;
  logic             controle;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] ula_in;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] topo;
  logic [PTR_W-1:0] count;
  logic             vazio;
  logic             cheio;
  logic             erro_overflow;
  logic             erro_underflow;

  pilha_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .wren           (wren),
    .controle       (controle),
    .data_in        (data_in),
    .ula_in         (ula_in),
    .data_out       (data_out),
    .topo           (topo),
    .count          (count),
    .vazio          (vazio),
    .cheio          (cheio),
    .erro_overflow  (erro_overflow),
    .erro_underflow (erro_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a plain queue, back = top of stack.
  logic [WIDTH-1:0] m_q [$];
  logic [WIDTH-1:0] m_out;
  logic             m_ovf;
  logic             m_unf;

  int n_tests;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [WIDTH-1:0] exp_topo;
    exp_topo = (m_q.size() > 0) ? m_q[$] : '0;
    check_eq({tag, ".count"}, 32'(count), 32'(m_q.size()));
    check_eq({tag, ".topo"}, 32'(topo), 32'(exp_topo));
    check_eq({tag, ".data_out"}, 32'(data_out), 32'(m_out));
    check_eq({tag, ".vazio"}, 32'(vazio), 32'(m_q.size() == 0));
    check_eq({tag, ".cheio"}, 32'(cheio), 32'(m_q.size() == DEPTH));
    check_eq({tag, ".ovf"}, 32'(erro_overflow), 32'(m_ovf));
    check_eq({tag, ".unf"}, 32'(erro_underflow), 32'(m_unf));
  endtask

  // One clock of stimulus, then advance the model and compare everything.
  task automatic step(input string tag, input logic rst, input logic en, input logic wr,
                      input logic ctl, input logic [WIDTH-1:0] din,
                      input logic [WIDTH-1:0] ula);
    @(negedge clock);
    reset    = rst;
    enable   = en;
    wren     = wr;
    controle = ctl;
    data_in  = din;
    ula_in   = ula;
    @(posedge clock);
    #1;
    if (rst) begin
      m_q.delete();
      m_out = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (en) begin
      if (wr) begin
        if (m_q.size() == DEPTH) m_ovf = 1'b1;
        else m_q.push_back(ctl ? ula : din);
      end else begin
        if (m_q.size() == 0) m_unf = 1'b1;
        else m_out = m_q.pop_back();
      end
    end
    check_all(tag);
  endtask

  task automatic push(input string tag, input logic [WIDTH-1:0] v);
    step(tag, 1'b0, 1'b1, 1'b1, 1'b0, v, 16'(~v));
  endtask

  task automatic pop(input string tag);
    step(tag, 1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    m_out    = '0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    reset    = 1'b1;
    enable   = 1'b0;
    wren     = 1'b0;
    controle = 1'b0;
    data_in  = '0;
    ula_in   = '0;

    // Reset and idle.
    step("rst", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    step("rst", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222);
    check_eq("reset_topo_const", 32'(topo), 32'h0);

    // Basic push/pop ordering.
    push("p1", 16'h0005);
    push("p2", 16'h00A0);
    push("p3", 16'h1234);
    check_eq("topo_before_pop", 32'(topo), 32'h1234);
    pop("pop1");
    check_eq("pop1_const", 32'(data_out), 32'h1234);
    pop("pop2");
    check_eq("pop2_const", 32'(data_out), 32'h00A0);
    pop("pop3");
    check_eq("pop3_const", 32'(data_out), 32'h0005);

    // ALU source select.
    step("ula_push", 1'b0, 1'b1, 1'b1, 1'b1, 16'h0001, 16'hBEEF);
    check_eq("ula_topo_const", 32'(topo), 32'hBEEF);
    pop("ula_pop");
    check_eq("ula_pop_const", 32'(data_out), 32'hBEEF);

    // Fill, overflow, then pop.
    for (int i = 1; i <= 16; i++) push("fill", 16'(i));
    push("ovf_push", 16'h00FF);
    check_eq("ovf_topo_const", 32'(topo), 32'd16);
    check_eq("ovf_flag_const", 32'(erro_overflow), 32'd1);
    pop("after_full");
    check_eq("after_full_const", 32'(data_out), 32'd16);

    // Drain, underflow, recover.
    while (m_q.size() > 0) pop("drain");
    pop("unf_pop");
    check_eq("unf_flag_const", 32'(erro_underflow), 32'd1);
    check_eq("unf_hold_const", 32'(data_out), 32'd1);
    push("after_unf", 16'd7);
    check_eq("after_unf_count", 32'(count), 32'd1);

    // Reset wins over a simultaneous push strobe.
    push("pre_rst_a", 16'hAAAA);
    push("pre_rst_b", 16'hBBBB);
    step("rst_push", 1'b1, 1'b1, 1'b1, 1'b0, 16'hCCCC, 16'hDDDD);
    push("post_rst_a", 16'h4321);
    push("post_rst_b", 16'h8765);
    for (int i = 0; i < 6; i++)
      step("idle_toggle", 1'b0, 1'b0, 1'(i), 1'(i >> 1), 16'($urandom), 16'($urandom));

    // Random traffic in phases biased toward full, toward empty, then mixed.
    for (int ph = 0; ph < 3; ph++) begin
      int bias;
      bias = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
      for (int i = 0; i < 300; i++) begin
        step("rand", ($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0),
             (32'($urandom_range(0, 99)) < 32'(bias)), 1'($urandom_range(0, 1)),
             16'($urandom), 16'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
